// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a write FIFO.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits, each bit held CLKS_PER_BIT clocks. Queued characters
// go out back to back with no idle gap between frames.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   wr_en        enqueue request, one character per cycle
//   wr_data      character to enqueue (DATA_BITS wide)
//   clr_overflow clears the sticky overflow flag
//   full         FIFO holds FIFO_DEPTH entries
//   empty        FIFO holds no entries
//   level        current FIFO occupancy
//   overflow     sticky, set when a write is dropped because the FIFO is full
//   busy         transmitter is not idle
//   tx           serial line, idle high
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          clr_overflow,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic        PAR_EN  = (PARITY != 0);
  localparam logic        PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_d;
  logic                   busy_d;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level_d;
  logic [DATA_BITS-1:0]   head;

  logic                   push_c, drop_c, pop_c, load_c, baud_last_c;

  // FIFO write qualification uses the registered full flag
  assign push_c      = wr_en && !full;
  assign drop_c      = wr_en && full;
  assign head        = mem[rd_ptr];
  assign baud_last_c = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign level_d     = level + LW'(push_c) - LW'(pop_c);

  // Next-state logic; load_c marks a frame start that pops the FIFO head
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load_c  = 1'b0;
    pop_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) load_c = 1'b1;
      end
      S_START: begin
        if (baud_last_c) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = PAR_EN ? S_PAR : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_PAR: begin
        if (baud_last_c) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when data is waiting
            if (!empty) load_c = 1'b1;
            else        state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_c) begin
      pop_c   = 1'b1;
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (^head) ^ PAR_ODD;
    end
  end

  // Line level follows the next state so tx changes on the same edge as state
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= busy_d;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      level   <= level_d;
      full    <= (level_d == LW'(FIFO_DEPTH));
      empty   <= (level_d == '0);
      // A dropped write wins over a simultaneous clear
      if (drop_c)            overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Storage array; reset only needs to clear the pointers
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Four instances cover 8N1, 8E1, 8O1 and 7N2 framing,
// all at CLKS_PER_BIT=4 with a 4-entry FIFO. Expected characters are queued
// when written; per-instance serial monitors decode frames and compare them.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en [4];
  logic [7:0] wr_data [3];
  logic [6:0] wr_data3;
  logic       clr_ovf = 1'b0;
  logic       full_o [4];
  logic       empty_o [4];
  logic [2:0] level_o [4];
  logic       ovf_o [4];
  logic       busy_o [4];
  logic       tx_o [4];

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  frame_cnt [4];
  bit  mon_off = 1'b0;
  logic [7:0] q0[$], q1[$], q2[$], q3[$];
  int  st0[$], st3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .clr_overflow(clr_ovf),
    .full(full_o[0]), .empty(empty_o[0]), .level(level_o[0]), .overflow(ovf_o[0]),
    .busy(busy_o[0]), .tx(tx_o[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .clr_overflow(clr_ovf),
    .full(full_o[1]), .empty(empty_o[1]), .level(level_o[1]), .overflow(ovf_o[1]),
    .busy(busy_o[1]), .tx(tx_o[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .clr_overflow(clr_ovf),
    .full(full_o[2]), .empty(empty_o[2]), .level(level_o[2]), .overflow(ovf_o[2]),
    .busy(busy_o[2]), .tx(tx_o[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY(0)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_data(wr_data3), .clr_overflow(clr_ovf),
    .full(full_o[3]), .empty(empty_o[3]), .level(level_o[3]), .overflow(ovf_o[3]),
    .busy(busy_o[3]), .tx(tx_o[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      2:       q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic pop_exp(input int k, output logic [7:0] d, output bit ok);
    ok = 1'b1;
    d  = '0;
    case (k)
      0:       if (q0.size() == 0) ok = 1'b0; else d = q0.pop_front();
      1:       if (q1.size() == 0) ok = 1'b0; else d = q1.pop_front();
      2:       if (q2.size() == 0) ok = 1'b0; else d = q2.pop_front();
      default: if (q3.size() == 0) ok = 1'b0; else d = q3.pop_front();
    endcase
  endtask

  task automatic drive(input int k, input logic [7:0] d, input bit expect_tx);
    wr_en[k] = 1'b1;
    if (k == 3) wr_data3 = d[6:0];
    else        wr_data[k] = d;
    if (expect_tx) push_exp(k, d);
  endtask

  task automatic release_wr();
    for (int k = 0; k < 4; k++) wr_en[k] = 1'b0;
  endtask

  // Serial decoder: compares every bit period of each frame with the queued character
  task automatic monitor(input int k);
    logic [7:0]  d;
    logic [15:0] fb;
    logic        o;
    bit          ok, ab;
    int          nb, st, db, sb, par;
    db  = (k == 3) ? 7 : 8;
    sb  = (k == 3) ? 2 : 1;
    par = (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    forever begin
      @(negedge clk);
      if (!mon_off && tx_o[k] === 1'b0) begin
        st = cyc;
        pop_exp(k, d, ok);
        chk($sformatf("u%0d_frame_expected", k), 32'(ok), 32'd1);
        fb = '0;
        nb = 1;
        for (int i = 0; i < db; i++) begin
          fb[4'(nb)] = d[3'(i)];
          nb++;
        end
        if (par != 0) begin
          fb[4'(nb)] = (^d) ^ (par == 2);
          nb++;
        end
        for (int i = 0; i < sb; i++) begin
          fb[4'(nb)] = 1'b1;
          nb++;
        end
        ab = 1'b0;
        for (int b = 0; b < nb && !ab; b++) begin
          o = fb[4'(b)];
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (mon_off) ab = 1'b1;
            else if (tx_o[k] !== fb[4'(b)]) o = tx_o[k];
          end
          if (!ab) chk($sformatf("u%0d_bit%0d", k, b), 32'(o), 32'(fb[4'(b)]));
        end
        if (!ab) begin
          frame_cnt[k]++;
          if (k == 0) st0.push_back(st);
          if (k == 3) st3.push_back(st);
        end
      end
    end
  endtask

  task automatic wait_frames(input int k, input int n, input int budget);
    int t;
    t = 0;
    while (frame_cnt[k] < n && t < budget) begin
      tick();
      t++;
    end
    chk($sformatf("u%0d_frames", k), 32'(frame_cnt[k]), 32'(n));
  endtask

  task automatic chk_start(input int k, input int w0, input int rel);
    int s;
    s = -1;
    if (k == 0 && st0.size() > 0) s = st0.pop_front();
    else if (k == 3 && st3.size() > 0) s = st3.pop_front();
    chk($sformatf("u%0d_start_at_%0d", k, rel), 32'(s - w0), 32'(rel));
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  initial begin
    int  w0;
    bit  seen;
    for (int k = 0; k < 4; k++) begin
      frame_cnt[k] = 0;
      wr_en[k]     = 1'b0;
    end
    for (int k = 0; k < 3; k++) wr_data[k] = '0;
    wr_data3 = '0;

    // Reset state
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d_rst_tx", k), 32'(tx_o[k]), 32'd1);
      chk($sformatf("u%0d_rst_busy", k), 32'(busy_o[k]), 32'd0);
      chk($sformatf("u%0d_rst_empty", k), 32'(empty_o[k]), 32'd1);
      chk($sformatf("u%0d_rst_full", k), 32'(full_o[k]), 32'd0);
      chk($sformatf("u%0d_rst_level", k), 32'(level_o[k]), 32'd0);
      chk($sformatf("u%0d_rst_ovf", k), 32'(ovf_o[k]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) tick();

    // Single 8N1 frame, latency and length
    w0 = cyc;
    drive(0, 8'hA5, 1'b1);
    tick();
    release_wr();
    chk("t1_empty_c1", 32'(empty_o[0]), 32'd0);
    chk("t1_level_c1", 32'(level_o[0]), 32'd1);
    chk("t1_tx_c1", 32'(tx_o[0]), 32'd1);
    tick();
    chk("t1_level_c2", 32'(level_o[0]), 32'd0);
    chk("t1_tx_c2", 32'(tx_o[0]), 32'd0);
    chk("t1_busy_c2", 32'(busy_o[0]), 32'd1);
    repeat (39) tick();
    chk("t1_tx_c41", 32'(tx_o[0]), 32'd1);
    chk("t1_busy_c41", 32'(busy_o[0]), 32'd1);
    tick();
    chk("t1_busy_c42", 32'(busy_o[0]), 32'd0);
    chk("t1_empty_c42", 32'(empty_o[0]), 32'd1);
    wait_frames(0, 1, 10);
    chk_start(0, w0, 2);
    repeat (3) tick();

    // Three back-to-back frames
    w0 = cyc;
    drive(0, 8'h11, 1'b1); tick();
    drive(0, 8'h22, 1'b1); tick();
    drive(0, 8'h33, 1'b1); tick();
    release_wr();
    chk("t2_level_c3", 32'(level_o[0]), 32'd2);
    repeat (38) tick();
    chk("t2_tx_c41", 32'(tx_o[0]), 32'd1);
    tick();
    chk("t2_tx_c42", 32'(tx_o[0]), 32'd0);
    chk("t2_level_c42", 32'(level_o[0]), 32'd1);
    repeat (40) tick();
    chk("t2_tx_c82", 32'(tx_o[0]), 32'd0);
    chk("t2_empty_c82", 32'(empty_o[0]), 32'd1);
    wait_frames(0, 4, 60);
    chk("t2_busy_end", 32'(busy_o[0]), 32'd0);
    chk_start(0, w0, 2);
    chk_start(0, w0, 42);
    chk_start(0, w0, 82);
    repeat (3) tick();

    // Fill to full, overflow on the sixth write
    w0 = cyc;
    drive(0, 8'h41, 1'b1); tick();
    chk("t3_level_c1", 32'(level_o[0]), 32'd1);
    drive(0, 8'h42, 1'b1); tick();
    chk("t3_level_c2", 32'(level_o[0]), 32'd1);
    drive(0, 8'h43, 1'b1); tick();
    chk("t3_level_c3", 32'(level_o[0]), 32'd2);
    drive(0, 8'h44, 1'b1); tick();
    chk("t3_level_c4", 32'(level_o[0]), 32'd3);
    drive(0, 8'h45, 1'b1); tick();
    chk("t3_level_c5", 32'(level_o[0]), 32'd4);
    chk("t3_full_c5", 32'(full_o[0]), 32'd1);
    chk("t3_ovf_c5", 32'(ovf_o[0]), 32'd0);
    drive(0, 8'h46, 1'b0); tick();
    release_wr();
    chk("t3_ovf_c6", 32'(ovf_o[0]), 32'd1);
    chk("t3_level_c6", 32'(level_o[0]), 32'd4);
    wait_frames(0, 9, 250);
    chk("t3_empty_end", 32'(empty_o[0]), 32'd1);
    chk("t3_ovf_sticky", 32'(ovf_o[0]), 32'd1);
    for (int i = 0; i < 5; i++) chk_start(0, w0, 2 + 40 * i);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", 32'(ovf_o[0]), 32'd0);
    repeat (3) tick();

    // Parity: even 0x07 and 0x03, odd 0x07
    w0 = cyc;
    drive(1, 8'h07, 1'b1);
    drive(2, 8'h07, 1'b1);
    tick();
    release_wr();
    drive(1, 8'h03, 1'b1);
    tick();
    release_wr();
    repeat (36) tick();
    chk("t4_even_par_07", 32'(tx_o[1]), 32'd1);
    chk("t4_odd_par_07", 32'(tx_o[2]), 32'd0);
    repeat (7) tick();
    chk("t4_odd_busy_c45", 32'(busy_o[2]), 32'd1);
    tick();
    chk("t4_odd_busy_c46", 32'(busy_o[2]), 32'd0);
    chk("t4_even_start2_c46", 32'(tx_o[1]), 32'd0);
    repeat (36) tick();
    chk("t4_even_par_03", 32'(tx_o[1]), 32'd0);
    wait_frames(1, 2, 20);
    wait_frames(2, 1, 5);
    repeat (3) tick();

    // 7N2 back-to-back
    w0 = cyc;
    drive(3, 8'h7F, 1'b1); tick();
    drive(3, 8'h7F, 1'b1); tick();
    release_wr();
    repeat (39) tick();
    chk("t5_tx_c41", 32'(tx_o[3]), 32'd1);
    chk("t5_busy_c41", 32'(busy_o[3]), 32'd1);
    tick();
    chk("t5_tx_c42", 32'(tx_o[3]), 32'd0);
    wait_frames(3, 2, 60);
    chk("t5_busy_end", 32'(busy_o[3]), 32'd0);
    chk_start(3, w0, 2);
    chk_start(3, w0, 42);
    repeat (3) tick();

    // Reset during the fourth data bit with two characters queued
    w0 = cyc;
    drive(0, 8'h00, 1'b1); tick();
    drive(0, 8'h5A, 1'b1); tick();
    drive(0, 8'h5A, 1'b1); tick();
    release_wr();
    repeat (16) tick();
    chk("t6_level_c19", 32'(level_o[0]), 32'd2);
    chk("t6_tx_c19", 32'(tx_o[0]), 32'd0);
    mon_off = 1'b1;
    rst = 1'b1;
    tick();
    chk("t6_tx_after_rst", 32'(tx_o[0]), 32'd1);
    chk("t6_level_after_rst", 32'(level_o[0]), 32'd0);
    chk("t6_empty_after_rst", 32'(empty_o[0]), 32'd1);
    chk("t6_busy_after_rst", 32'(busy_o[0]), 32'd0);
    rst = 1'b0;
    q0.delete();
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (tx_o[0] !== 1'b1) seen = 1'b1;
    end
    chk("t6_no_start", 32'(seen), 32'd0);

    chk("sb_u1_drained", 32'(q1.size()), 32'd0);
    chk("sb_u2_drained", 32'(q2.size()), 32'd0);
    chk("sb_u3_drained", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated write FIFO. It is the successor to the fixed 8N1, single-byte uart instance driven by memory_access. The store path can queue up to FIFO_DEPTH characters without stalling on each one. Frame format (data width, parity, stop bits) and bit period are set at elaboration, and a sticky overflow flag reports dropped writes to software.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (>=2; 868 = 100 MHz / 115200)
DATA_BITS, 8, data bits per frame (5..8)
FIFO_DEPTH, 16, FIFO entries (power of two, >=2)
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  enqueue request, one character per cycle
wr_data  in  DATA_BITS  character to enqueue
clr_overflow  in  1  clears overflow
full  out  1  FIFO holds FIFO_DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; set when a write is dropped
busy  out  1  transmitter not in IDLE
tx  out  1  serial line, idle high

Behaviour:
- One clock. rst is synchronous and active-high.
- Reset values: tx=1, busy=0, full=0, empty=1, level=0, overflow=0, FSM=IDLE, read/write pointers=0.
- Reset mid-frame: the frame is truncated, tx=1 from the next edge, all FIFO contents are discarded, and nothing further is sent until a new write.
- FIFO write: accepted when wr_en && !full, evaluated on registered full.
  - A write while full is dropped even if a pop occurs in the same cycle. It sets overflow.
  - clr_overflow clears overflow. If clr_overflow and a dropped write occur together, set wins.
- FIFO pop: occurs only on FSM frame start (see below).
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo FIFO_DEPTH. full/empty/level are derived from registered state.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If !empty, pop the head into a shift register, go to START, reset the bit counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles. After DATA_BITS bits, go to PAR if PARITY!=0, else STOP.
  - PAR: tx = XOR of data bits (even) or its inverse (odd), held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last STOP cycle, if !empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: write at cycle 0 with FIFO empty and FSM in IDLE:
  - empty=0 at cycle 1;
  - pop in cycle 1, so level returns to 0 at cycle 2;
  - tx falls at cycle 2.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Back-to-back frames are contiguous while the FIFO is non-empty.
- busy = (state != IDLE). It falls the cycle after the last STOP cycle when the FIFO is empty.
- Baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state or bit change. No fractional baud.
- Unused upper wr_data bits do not exist: the data width equals DATA_BITS.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, write 0xA5 at cycle 0 from idle -> tx low at cycles 2-5, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high cycles 38-41, busy=0 at cycle 42, total frame 40 cycles.
2. Same config, writes 0x11, 0x22, 0x33 on consecutive cycles -> three frames with start bits at cycles 2, 42, 82, no idle gap, empty=1 after the third pop.
3. FIFO_DEPTH=4, writes A..F on cycles 0-5 from idle:
   - level sequence 1,1,2,3,4;
   - full=1 at cycle 5, F dropped, overflow=1;
   - A..E transmitted in order;
   - clr_overflow -> overflow=0 next cycle.
4. PARITY=1, write 0x07 -> parity bit 1. PARITY=2, write 0x07 -> parity bit 0. PARITY=1, write 0x03 -> parity bit 0. Frame length 44 cycles at CLKS_PER_BIT=4.
5. STOP_BITS=2, DATA_BITS=7, write 0x7F -> 7 data bits of 1, stop high 8 cycles, next queued frame starts exactly 40 cycles after the previous start.
6. rst asserted during the 4th data bit with 2 entries queued -> tx=1, level=0, empty=1, busy=0 on the next edge. No further start bit occurs within 100 cycles.
